fcl_write_controller: RTL and testbench

- Write-side counterpart to the FCL read address generator. Accepts a stream of feature words from the preceding layer (valid/ready) and issues sequential buffer write strobes, addresses and data into the FCL input buffer.
- Two write modes, selected by iSTATE and latched at iSTART:
  - FC1 mode (iSTATE == 3'b101).
  - FC2 mode (any other iSTATE).
- Signals frame completion to the sequencer so the read side can start.

---
 rtl/fcl_write_controller_if.sv | 28 ++
 rtl/fcl_write_controller.sv | 117 +++++++++++
 tb/tb_fcl_write_controller.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fcl_write_controller_if.sv
// Write-side bus bundle for the FCL input buffer: upstream word stream, frame control and buffer write port.
// Controller takes the slave modport; the upstream/sequencer side takes the master modport.
interface fcl_write_controller_if #(
    parameter int WL = 16,
    parameter int AW = 9
);
    logic          iSTART;
    logic [2:0]    iSTATE;
    logic          iDATA_VALID;
    logic [WL-1:0] iDATA;
    logic          oREADY;
    logic          oWr_EN;
    logic [AW-1:0] oWr_ADDR;
    logic [WL-1:0] oWr_DATA;
    logic          oWr_BANK;
    logic          oBUSY;
    logic          oWr_DONE;

    modport master (
        output iSTART, iSTATE, iDATA_VALID, iDATA,
        input  oREADY, oWr_EN, oWr_ADDR, oWr_DATA, oWr_BANK, oBUSY, oWr_DONE
    );

    modport slave (
        input  iSTART, iSTATE, iDATA_VALID, iDATA,
        output oREADY, oWr_EN, oWr_ADDR, oWr_DATA, oWr_BANK, oBUSY, oWr_DONE
    );
endinterface

// File: rtl/fcl_write_controller.sv
// FCL input-buffer write controller: streams accepted words to sequential buffer addresses per frame.
// Optional macro FCL_WR_BANK_SWAP_EN makes oWr_BANK ping-pong after every completed frame.
module fcl_write_controller #(
    parameter int WL        = 16,
    parameter int AW        = 9,
    parameter int FC1_DEPTH = 112,
    parameter int FC1_BASE  = 0,
    parameter int FC2_DEPTH = 12,
    parameter int FC2_BASE  = 252
) (
    input logic                  iCLK,
    input logic                  iRSTn,
    fcl_write_controller_if.slave bus
);
    localparam logic [2:0] FC1_STATE = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic          fc1_reg, fc1_next;
    logic [AW-1:0] cnt_reg, cnt_next;
    logic          wr_en_reg;
    logic [AW-1:0] wr_addr_reg;
    logic [WL-1:0] wr_data_reg;
    logic          xfer;
    logic [AW-1:0] base;
    logic [AW-1:0] last_cnt;

    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            state_reg <= IDLE;
            fc1_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            fc1_reg   <= fc1_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        fc1_next   = fc1_reg;
        cnt_next   = cnt_reg;
        xfer       = 1'b0;
        base       = fc1_reg ? AW'(FC1_BASE) : AW'(FC2_BASE);
        last_cnt   = fc1_reg ? AW'(FC1_DEPTH - 1) : AW'(FC2_DEPTH - 1);
        case (state_reg)
            IDLE: begin
                if (bus.iSTART) begin
                    fc1_next   = (bus.iSTATE == FC1_STATE);
                    cnt_next   = '0;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                xfer = bus.iDATA_VALID;
                if (xfer) begin
                    cnt_next = cnt_reg + AW'(1);
                    if (cnt_reg == last_cnt) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Write port is registered so each accepted word appears exactly one cycle later.
    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            wr_en_reg <= xfer;
            if (xfer) begin
                wr_addr_reg <= base + cnt_reg;
                wr_data_reg <= bus.iDATA;
            end
        end
    end

    assign bus.oREADY   = (state_reg == WRITE);
    assign bus.oBUSY    = (state_reg != IDLE);
    assign bus.oWr_DONE = (state_reg == DONE);
    assign bus.oWr_EN   = wr_en_reg;
    assign bus.oWr_ADDR = wr_addr_reg;
    assign bus.oWr_DATA = wr_data_reg;

`ifdef FCL_WR_BANK_SWAP_EN
    // Bank flips after the DONE cycle so the final write still lands in the frame's own bank.
    logic bank_reg;

    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            bank_reg <= 1'b0;
        end else if (state_reg == DONE) begin
            bank_reg <= ~bank_reg;
        end
    end

    assign bus.oWr_BANK = bank_reg;
`else
    assign bus.oWr_BANK = 1'b0;
`endif

endmodule

// File: tb/tb_fcl_write_controller.sv
// Randomized scoreboard bench for fcl_write_controller: driver models frames, monitor checks every cycle.
module tb_fcl_write_controller;
    localparam int WL = 16;
    localparam int AW = 9;

    typedef struct {
        int addr;
        int data;
        int last;
        int bank;
        int due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;

    exp_t sb[$];
    bit   exp_check = 1'b0;
    bit   exp_ready, exp_busy, exp_zero, exp_bank;
    bit   bank_model = 1'b0;
    int   hold_addr = 0;
    int   hold_data = 0;

    fcl_write_controller_if #(.WL(WL), .AW(AW)) bus ();

    fcl_write_controller #(.WL(WL), .AW(AW)) dut (
        .iCLK (clk),
        .iRSTn(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc_cnt);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input bit ready, input bit busy, input bit zero);
        exp_ready = ready;
        exp_busy  = busy;
        exp_zero  = zero;
        exp_bank  = bank_model;
        exp_check = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            bus.iSTART      = 1'b0;
            bus.iDATA_VALID = 1'($urandom % 2);
            bus.iDATA       = 16'($urandom);
            set_exp(1'b0, 1'b0, 1'b0);
        end
    endtask

    // vmode: 0 = always valid with data = index, 1 = valid every other cycle, 2 = random gaps.
    task automatic run_frame(input logic [2:0] st, input int vmode, input bit noise, input int abort_after);
        int   depth, base, idx, wc;
        bit   v;
        exp_t e;
        depth = (st == 3'b101) ? 112 : 12;
        base  = (st == 3'b101) ? 0 : 252;
        step();
        bus.iSTART      = 1'b1;
        bus.iSTATE      = st;
        bus.iDATA_VALID = 1'($urandom % 2);
        bus.iDATA       = 16'($urandom);
        set_exp(1'b0, 1'b0, 1'b0);
        idx = 0;
        wc  = 0;
        while (idx < depth) begin
            step();
            bus.iSTART = noise ? 1'($urandom % 3 == 0) : 1'b0;
            if (noise) bus.iSTATE = 3'($urandom);
            case (vmode)
                0:       v = 1'b1;
                1:       v = (wc % 2) == 1;
                default: v = ($urandom % 4) != 0;
            endcase
            bus.iDATA_VALID = v;
            bus.iDATA       = (vmode == 0) ? 16'(idx) : 16'($urandom);
            set_exp(1'b1, 1'b1, 1'b0);
            if (abort_after >= 0 && idx == abort_after) begin
                rst_n           = 1'b0;
                bus.iDATA_VALID = 1'b1;
                bank_model      = 1'b0;
                step();
                rst_n           = 1'b1;
                bus.iSTART      = 1'b0;
                bus.iDATA_VALID = 1'b0;
                set_exp(1'b0, 1'b0, 1'b1);
                return;
            end
            if (v) begin
                e.addr = (base + idx) % 512;
                e.data = int'(bus.iDATA);
                e.last = (idx == depth - 1) ? 1 : 0;
                e.bank = int'(bank_model);
                e.due  = cyc_cnt + 1;
                sb.push_back(e);
                idx++;
            end
            wc++;
        end
        step();
        bus.iSTART      = noise ? 1'b1 : 1'b0;
        bus.iDATA_VALID = 1'($urandom % 2);
        set_exp(1'b0, 1'b1, 1'b0);
`ifdef FCL_WR_BANK_SWAP_EN
        bank_model = ~bank_model;
`endif
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_check) begin
            chk("ready", 32'(bus.oREADY), 32'(exp_ready));
            chk("busy", 32'(bus.oBUSY), 32'(exp_busy));
            chk("bank", 32'(bus.oWr_BANK), 32'(exp_bank));
            if (bus.oWr_EN || (sb.size() > 0 && sb[0].due <= cyc_cnt)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write_en", 32'(bus.oWr_EN), 0);
                end else begin
                    e = sb.pop_front();
                    chk("write_en", 32'(bus.oWr_EN), 1);
                    chk("write_cycle", cyc_cnt, e.due);
                    chk("write_addr", 32'(bus.oWr_ADDR), e.addr);
                    chk("write_data", 32'(bus.oWr_DATA), e.data);
                    chk("write_done", 32'(bus.oWr_DONE), e.last);
                    chk("write_bank", 32'(bus.oWr_BANK), e.bank);
                    hold_addr = e.addr;
                    hold_data = e.data;
                end
            end else begin
                chk("done_without_write", 32'(bus.oWr_DONE), 0);
                if (exp_zero) begin
                    hold_addr = 0;
                    hold_data = 0;
                end
                chk("hold_addr", 32'(bus.oWr_ADDR), hold_addr);
                chk("hold_data", 32'(bus.oWr_DATA), hold_data);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.iSTART      = 1'b0;
        bus.iSTATE      = 3'b000;
        bus.iDATA_VALID = 1'b0;
        bus.iDATA       = '0;
        step();
        set_exp(1'b0, 1'b0, 1'b1);
        step();
        rst_n = 1'b1;
        set_exp(1'b0, 1'b0, 1'b1);

        run_frame(3'b101, 0, 1'b0, -1);
        idle(2);
        run_frame(3'b010, 0, 1'b0, -1);
        idle(1);
        run_frame(3'b010, 1, 1'b0, -1);
        idle(1);
        run_frame(3'b101, 0, 1'b0, 50);
        run_frame(3'b101, 2, 1'b1, -1);
        idle(1);
        run_frame(3'b000, 2, 1'b1, -1);
        run_frame(3'b111, 0, 1'b0, -1);
        for (int i = 0; i < 4; i++) begin
            run_frame(($urandom % 2) ? 3'b101 : 3'($urandom % 5), int'($urandom % 3), 1'($urandom % 2), -1);
            idle(int'($urandom % 3));
        end
        idle(3);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
